// File: rtl/iob_timer_ctrl.sv
// Timer control stage: prescaler, one-shot/periodic FSM and done flag.
// It steers an external loadable up-counter and reads its value back on cnt_i.
module iob_timer_ctrl #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PRESC_W = 16
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic               cke_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               mode_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic [DATA_W-1:0]  period_i,
    input  logic [DATA_W-1:0]  cnt_i,
    output logic               cnt_rst_o,
    output logic               cnt_en_o,
    output logic               cnt_ld_o,
    output logic [DATA_W-1:0]  cnt_ld_val_o,
    output logic               tick_o,
    output logic               expire_o,
    output logic               busy_o,
    output logic               done_o,
    input  logic               done_clr_i
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [PRESC_W-1:0]   presc_cnt_q, presc_cnt_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [DATA_W-1:0]    period_q, period_d;
    logic                 mode_q, mode_d;
    logic                 done_q, done_d;

    logic                 tick_hit;
    logic                 at_end;
    logic                 done_set;

    // period_q is never 0 (stored as 1), so period_q-1 cannot wrap
    assign tick_hit = (presc_cnt_q == presc_q);
    assign at_end   = (cnt_i >= (period_q - DATA_W'(1)));

    assign cnt_rst_o    = rst_i;
    assign cnt_ld_val_o = '0;
    assign busy_o       = (state_q == RUN);
    assign done_o       = done_q;

    // Next-state and counter-steering logic; start wins over stop and tick/expire
    always_comb begin
        state_d     = state_q;
        presc_cnt_d = presc_cnt_q;
        presc_d     = presc_q;
        period_d    = period_q;
        mode_d      = mode_q;
        done_d      = done_q;
        done_set    = 1'b0;
        cnt_en_o    = 1'b0;
        cnt_ld_o    = 1'b0;
        tick_o      = 1'b0;
        expire_o    = 1'b0;

        if (rst_i) begin
            state_d     = IDLE;
            presc_cnt_d = '0;
            presc_d     = '0;
            period_d    = '0;
            mode_d      = 1'b0;
            done_d      = 1'b0;
        end else if (cke_i) begin
            if (start_i) begin
                mode_d      = mode_i;
                presc_d     = presc_i;
                period_d    = (period_i == '0) ? DATA_W'(1) : period_i;
                presc_cnt_d = '0;
                state_d     = RUN;
                cnt_en_o    = 1'b1;
                cnt_ld_o    = 1'b1;
            end else if (state_q == RUN) begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (tick_hit) begin
                    tick_o      = 1'b1;
                    presc_cnt_d = '0;
                    if (at_end) begin
                        expire_o = 1'b1;
                        if (mode_q) begin
                            cnt_en_o = 1'b1;
                            cnt_ld_o = 1'b1;
                        end else begin
                            done_set = 1'b1;
                            state_d  = IDLE;
                        end
                    end else begin
                        cnt_en_o = 1'b1;
                    end
                end else begin
                    presc_cnt_d = presc_cnt_q + PRESC_W'(1);
                end
            end

            // A coincident set beats the clear
            if (done_set) begin
                done_d = 1'b1;
            end else if (done_clr_i) begin
                done_d = 1'b0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= IDLE;
            presc_cnt_q <= '0;
            presc_q     <= '0;
            period_q    <= '0;
            mode_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_cnt_q <= presc_cnt_d;
            presc_q     <= presc_d;
            period_q    <= period_d;
            mode_q      <= mode_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_iob_timer_ctrl.sv
// Directed bench for iob_timer_ctrl with a behavioural model of the loadable counter.
module tb_iob_timer_ctrl;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PRESC_W = 16;

    logic               clk;
    logic               arst;
    logic               cke;
    logic               rst;
    logic               start;
    logic               stop;
    logic               mode;
    logic [PRESC_W-1:0] presc;
    logic [DATA_W-1:0]  period;
    logic [DATA_W-1:0]  cnt;
    logic               cnt_rst_o;
    logic               cnt_en_o;
    logic               cnt_ld_o;
    logic [DATA_W-1:0]  cnt_ld_val_o;
    logic               tick_o;
    logic               expire_o;
    logic               busy_o;
    logic               done_o;
    logic               done_clr;

    int n_checks = 0;
    int n_fail   = 0;

    iob_timer_ctrl #(.DATA_W(DATA_W), .PRESC_W(PRESC_W)) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .cke_i        (cke),
        .rst_i        (rst),
        .start_i      (start),
        .stop_i       (stop),
        .mode_i       (mode),
        .presc_i      (presc),
        .period_i     (period),
        .cnt_i        (cnt),
        .cnt_rst_o    (cnt_rst_o),
        .cnt_en_o     (cnt_en_o),
        .cnt_ld_o     (cnt_ld_o),
        .cnt_ld_val_o (cnt_ld_val_o),
        .tick_o       (tick_o),
        .expire_o     (expire_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .done_clr_i   (done_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream loadable up-counter
    always_ff @(posedge clk or posedge arst) begin
        if (arst)           cnt <= '0;
        else if (cnt_rst_o) cnt <= '0;
        else if (cnt_en_o)  cnt <= cnt_ld_o ? cnt_ld_val_o : cnt + DATA_W'(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic start_timer(input logic m, input logic [PRESC_W-1:0] p, input logic [DATA_W-1:0] per);
        mode   = m;
        presc  = p;
        period = per;
        start  = 1'b1;
        @(negedge clk);
        check_eq("start_ld", 64'(cnt_ld_o), 64'd1);
        check_eq("start_en", 64'(cnt_en_o), 64'd1);
        step();
        start = 1'b0;
    endtask

    initial begin
        arst = 1'b1; rst = 1'b0; cke = 1'b1; start = 1'b0; stop = 1'b0;
        mode = 1'b0; presc = '0; period = '0; done_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;

        // reset state
        @(negedge clk);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_done", 64'(done_o), 64'd0);
        check_eq("rst_tick", 64'(tick_o), 64'd0);
        check_eq("rst_exp", 64'(expire_o), 64'd0);
        check_eq("rst_cntrst", 64'(cnt_rst_o), 64'd0);
        check_eq("ld_val", 64'(cnt_ld_val_o), 64'd0);
        step();

        // one-shot presc=2 period=4; clear coincides with expiry at cycle 12
        start_timer(1'b0, 16'd2, 32'd4);
        for (int c = 1; c <= 12; c++) begin
            done_clr = (c == 12);
            @(negedge clk);
            check_eq("os_tick", 64'(tick_o), 64'(c % 3 == 0));
            check_eq("os_exp", 64'(expire_o), 64'(c == 12));
            check_eq("os_busy", 64'(busy_o), 64'd1);
            if (c == 10) check_eq("os_cnt10", 64'(cnt), 64'd3);
            step();
        end
        done_clr = 1'b0;
        check_eq("os_done", 64'(done_o), 64'd1);
        check_eq("os_idle", 64'(busy_o), 64'd0);
        check_eq("os_hold", 64'(cnt), 64'd3);
        step();
        check_eq("os_hold2", 64'(cnt), 64'd3);
        done_clr = 1'b1;
        step();
        done_clr = 1'b0;
        check_eq("os_clr", 64'(done_o), 64'd0);

        // periodic presc=0 period=3, ten periods
        start_timer(1'b1, 16'd0, 32'd3);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            check_eq("per_cnt", 64'(cnt), 64'((c - 1) % 3));
            check_eq("per_exp", 64'(expire_o), 64'(c % 3 == 0));
            check_eq("per_busy", 64'(busy_o), 64'd1);
            step();
        end
        check_eq("per_done", 64'(done_o), 64'd0);
        go_idle();

        // period 0 behaves as 1
        start_timer(1'b1, 16'd0, 32'd0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check_eq("p0_exp", 64'(expire_o), 64'd1);
            check_eq("p0_cnt", 64'(cnt), 64'd0);
            step();
        end
        go_idle();

        // stop while cnt=2
        start_timer(1'b1, 16'd0, 32'd5);
        step();
        step();
        stop = 1'b1;
        @(negedge clk);
        check_eq("stop_cnt_pre", 64'(cnt), 64'd2);
        check_eq("stop_tick", 64'(tick_o), 64'd0);
        check_eq("stop_en", 64'(cnt_en_o), 64'd0);
        step();
        stop = 1'b0;
        check_eq("stop_busy", 64'(busy_o), 64'd0);
        check_eq("stop_done", 64'(done_o), 64'd0);
        step();
        step();
        check_eq("stop_hold", 64'(cnt), 64'd2);

        // restart coinciding with an expiry
        start_timer(1'b1, 16'd0, 32'd2);
        step();
        start = 1'b1;
        @(negedge clk);
        check_eq("rs_cnt_pre", 64'(cnt), 64'd1);
        check_eq("rs_exp", 64'(expire_o), 64'd0);
        check_eq("rs_ld", 64'(cnt_ld_o), 64'd1);
        check_eq("rs_en", 64'(cnt_en_o), 64'd1);
        step();
        start = 1'b0;
        @(negedge clk);
        check_eq("rs_cnt0", 64'(cnt), 64'd0);
        check_eq("rs_exp0", 64'(expire_o), 64'd0);
        step();
        @(negedge clk);
        check_eq("rs_exp1", 64'(expire_o), 64'd1);
        check_eq("rs_cnt1", 64'(cnt), 64'd1);
        step();
        go_idle();

        // cke low for 5 cycles delays a one-shot expiry from cycle 4 to 9
        start_timer(1'b0, 16'd0, 32'd4);
        for (int c = 1; c <= 10; c++) begin
            cke = !(c >= 2 && c <= 6);
            @(negedge clk);
            check_eq("cke_exp", 64'(expire_o), 64'(c == 9));
            if (!cke) begin
                check_eq("cke_en", 64'(cnt_en_o), 64'd0);
                check_eq("cke_tick", 64'(tick_o), 64'd0);
            end
            step();
        end
        cke = 1'b1;
        check_eq("cke_done", 64'(done_o), 64'd1);
        check_eq("cke_busy", 64'(busy_o), 64'd0);
        check_eq("cke_cnt", 64'(cnt), 64'd3);

        // async reset mid-run clears everything immediately
        start_timer(1'b1, 16'd0, 32'd3);
        check_eq("ar_busy_pre", 64'(busy_o), 64'd1);
        check_eq("ar_done_pre", 64'(done_o), 64'd1);
        arst = 1'b1;
        #1;
        check_eq("ar_busy", 64'(busy_o), 64'd0);
        check_eq("ar_done", 64'(done_o), 64'd0);
        check_eq("ar_tick", 64'(tick_o), 64'd0);
        check_eq("ar_exp", 64'(expire_o), 64'd0);
        step();
        arst = 1'b0;
        step();
        @(negedge clk);
        check_eq("ar_idle", 64'(busy_o), 64'd0);
        check_eq("ar_idle_tick", 64'(tick_o), 64'd0);
        step();

        // synchronous soft reset
        start_timer(1'b1, 16'd0, 32'd3);
        rst = 1'b1;
        #1;
        check_eq("sr_cntrst", 64'(cnt_rst_o), 64'd1);
        check_eq("sr_tick", 64'(tick_o), 64'd0);
        check_eq("sr_en", 64'(cnt_en_o), 64'd0);
        step();
        rst = 1'b0;
        check_eq("sr_busy", 64'(busy_o), 64'd0);
        check_eq("sr_cnt", 64'(cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_timer_ctrl.md
Name: iob_timer_ctrl

Overview:
Control stage directly upstream of the loadable up-counter. It drives the counter's soft reset, enable, load and load-value inputs, and reads back the counter value. Together the two form a programmable timer with a clock prescaler, one-shot or periodic mode, expiry pulse and sticky done flag. The counter itself holds the count; this block holds the prescaler, the FSM and the flags.

Parameters:
DATA_W, 32, width of counter value, period and load value
PRESC_W, 16, width of prescaler count and prescaler setting

Ports:
clk_i  input  1  system clock
arst_i  input  1  asynchronous reset, active-high
cke_i  input  1  clock enable; when low, all state holds and cnt_en_o is forced low
rst_i  input  1  synchronous soft reset; same effect as arst_i
start_i  input  1  start/restart timer (pulse)
stop_i  input  1  abort timer (pulse)
mode_i  input  1  0 = one-shot, 1 = periodic; sampled on start
presc_i  input  PRESC_W  ticks occur every presc_i+1 cycles; sampled on start
period_i  input  DATA_W  counts per expiry; 0 treated as 1; sampled on start
cnt_i  input  DATA_W  counter value fed back from the counter
cnt_rst_o  output  1  counter synchronous reset
cnt_en_o  output  1  counter enable
cnt_ld_o  output  1  counter load select
cnt_ld_val_o  output  DATA_W  counter load value; constant 0
tick_o  output  1  one-cycle pulse on each prescaled tick
expire_o  output  1  one-cycle pulse when the count reaches period
busy_o  output  1  high in RUN
done_o  output  1  sticky; set on one-shot expiry
done_clr_i  input  1  clears done_o

Behaviour:
- Reset (arst_i or rst_i): state IDLE; prescaler 0; stored mode/presc/period 0; done_o 0; all pulse outputs 0. cnt_rst_o = rst_i | (arst_i-derived reset is the counter's own).
- States:
  - IDLE. On start_i, latch mode_i, presc_i and period_i (0 -> 1). Drive cnt_ld_o=1 and cnt_en_o=1 for that cycle, which loads 0 into the counter. Clear the prescaler and go to RUN.
  - RUN. busy_o=1. The prescaler increments each cycle. When prescaler == stored presc: tick_o=1 and prescaler goes to 0.
    - On a tick with cnt_i < period-1: cnt_en_o=1, cnt_ld_o=0, so the counter increments.
    - On a tick with cnt_i >= period-1: expire_o=1.
      - Periodic: cnt_ld_o=1, cnt_en_o=1 (reload 0); stay in RUN.
      - One-shot: cnt_en_o=0, so the counter holds at period-1; done_o is set and the FSM returns to IDLE.
- Latency: the first tick comes presc+1 cycles after the start cycle. Expiry comes period*(presc+1) cycles after start.
- stop_i in RUN: go to IDLE next cycle. No tick, no expire, no done. The counter holds its value. stop_i in IDLE: no effect.
- start_i in RUN: restart. Re-latch the settings, reload 0, clear the prescaler. start_i has priority over stop_i and over a coincident tick or expire; no expire_o is produced that cycle.
- done_clr_i clears done_o. If a done-set coincides with done_clr_i, the set wins.
- cke_i=0 freezes the FSM, prescaler and flags. All pulse outputs and cnt_en_o are 0 during the freeze.
- cnt_ld_val_o is constant 0. cnt_i is compared unsigned, full DATA_W width.
- Outputs are combinational from registered state plus cnt_i, start_i and stop_i. There is no combinational path from cnt_i to the counter's data, so no loop is formed.

Test Plan:
- Reset: assert arst_i mid-RUN -> busy_o, done_o, tick_o and expire_o go to 0 immediately; the FSM is in IDLE after release.
- One-shot: presc=2, period=4, mode=0, start at cycle 0 -> tick_o at cycles 3, 6, 9, 12. The counter reaches 3 at cycle 10. expire_o and the done_o set occur at cycle 12. busy_o falls and the counter holds 3.
- Periodic: presc=0, period=3, mode=1 -> expire_o every 3 cycles. The counter sequence is 0, 1, 2, 0, 1, 2 for 10 periods; busy_o stays 1.
- Period 0: presc=0, period=0, periodic -> expire_o every cycle; the counter stays 0.
- Stop and restart: stop_i while cnt_i=2 -> IDLE, counter holds 2, done_o stays 0. start_i with a coincident expiry -> no expire_o, counter reloads 0.
- Flags and clock enable: done_clr_i in the same cycle as a one-shot expiry -> done_o=1. A later done_clr_i -> done_o=0. Holding cke_i=0 for 5 cycles mid-RUN delays the expiry by exactly 5 cycles.
